// File: rtl/hdr_bit_pack_pkg.sv
// Shared definitions for the JPEG2000 packet-header bit packer:
// serializer state encoding, marker/stuff byte values and default widths.
package j2k_hdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_SHIFT,
    ST_FLUSH,
    ST_STUFF,
    ST_EMIT
  } hdr_state_e;

  localparam logic [7:0] J2K_FF         = 8'hFF;
  localparam logic [7:0] J2K_STUFF_BYTE = 8'h00;

  localparam int unsigned HDR_DATA_W_DEF = 32;
  localparam int unsigned BIT_CNT_W_DEF  = 6;

endpackage

// File: rtl/hdr_byte_to_word.sv
// Collects closed header bytes big-endian into an AXI-stream word and owns the
// output register; back-pressures the serializer when a word cannot move out.
module hdr_byte_to_word #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  localparam int unsigned KW = $clog2(KEEP_W + 1);

  logic [DATA_W-1:0] r_buf;
  logic [KW-1:0]     r_k;

  logic              w_out_free;
  logic              w_need_move;
  logic              w_acc;
  logic              w_flush_move;
  logic [DATA_W-1:0] w_word;

  function automatic logic [KEEP_W-1:0] keep_mask(input logic [KW-1:0] n);
    keep_mask = ~({KEEP_W{1'b1}} >> n);
  endfunction

  assign w_out_free   = !m_valid_o || m_ready_i;
  // A byte that completes or terminates a word goes straight to the output
  // register, so it is only taken when that register can accept it.
  assign w_need_move  = byte_last_i || (r_k == KW'(KEEP_W - 1));
  assign byte_ready_o = !w_need_move || w_out_free;
  assign w_acc        = byte_valid_i && byte_ready_o;
  assign w_flush_move = flush_i && (r_k != '0) && w_out_free;
  assign flush_done_o = flush_i && ((r_k == '0) || w_out_free);
  assign w_word       = r_buf | ({byte_i, {(DATA_W-8){1'b0}}} >> {r_k, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_k       <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_keep_o  <= '0;
      m_last_o  <= 1'b0;
    end else begin
      if (m_ready_i) m_valid_o <= 1'b0;
      if (w_acc && w_need_move) begin
        m_valid_o <= 1'b1;
        m_data_o  <= w_word;
        m_keep_o  <= keep_mask(KW'(r_k + 1'b1));
        m_last_o  <= byte_last_i;
        r_buf     <= '0;
        r_k       <= '0;
      end else if (w_acc) begin
        r_buf <= w_word;
        r_k   <= KW'(r_k + 1'b1);
      end else if (w_flush_move) begin
        m_valid_o <= 1'b1;
        m_data_o  <= r_buf;
        m_keep_o  <= keep_mask(r_k);
        m_last_o  <= 1'b1;
        r_buf     <= '0;
        r_k       <= '0;
      end
    end
  end

endmodule

// File: rtl/hdr_bit_pack.sv
// JPEG2000 packet-header bit packer: serializes fields MSB-first with 0xFF bit
// stuffing into AXI-stream words. Define HDR_PACK_STAT_EN for the byte-count ports.
module hdr_bit_pack
  import j2k_hdr_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned KEEP_W     = DATA_W / 8,
  parameter int unsigned HDR_DATA_W = HDR_DATA_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  hdr_last_i,
  input  logic                  insert_zero_i,
  input  logic [BIT_CNT_W-1:0]  bit_cnt_i,
  input  logic [HDR_DATA_W-1:0] hdr_data_i,
  output logic                  hdr_ready_o,
  output logic                  m_axis_hdr_tx_valid_o,
  output logic [DATA_W-1:0]     m_axis_hdr_tx_data_o,
  output logic [KEEP_W-1:0]     m_axis_hdr_tx_keep_o,
  output logic                  m_axis_hdr_tx_last_o,
`ifdef HDR_PACK_STAT_EN
  output logic [15:0]           hdr_len_o,
  output logic                  hdr_len_valid_o,
`endif
  input  logic                  m_axis_hdr_tx_ready_i
);

  hdr_state_e            r_state;
  logic [HDR_DATA_W-1:0] r_data;
  logic [BIT_CNT_W-1:0]  r_cnt;
  logic                  r_last;
  logic                  r_stuff;
  logic [7:0]            r_byte;
  logic [2:0]            r_bitpos;
  logic                  r_ff;

  logic [BIT_CNT_W-1:0]  w_cnt_sat;
  logic [2:0]            w_pos;
  logic [7:0]            w_shift_byte;
  logic                  w_shift_close;
  logic                  w_shift_ff;
  logic                  w_byte_valid;
  logic [7:0]            w_byte;
  logic                  w_byte_last;
  logic                  w_byte_ready;
  logic                  w_flush;
  logic                  w_flush_done;

  assign hdr_ready_o = (r_state == ST_IDLE);
  assign w_flush     = (r_state == ST_EMIT);
  assign w_cnt_sat   = (bit_cnt_i > BIT_CNT_W'(HDR_DATA_W)) ? BIT_CNT_W'(HDR_DATA_W) : bit_cnt_i;

  always_comb begin
    // After a stuffed 0xFF the fresh byte starts at bit 6; bit 7 stays 0.
    w_pos         = (r_bitpos == 3'd0 && r_ff && r_stuff) ? 3'd1 : r_bitpos;
    w_shift_byte  = r_byte | (8'(r_data[HDR_DATA_W-1]) << (3'd7 - w_pos));
    w_shift_close = (w_pos == 3'd7);
    w_shift_ff    = (w_shift_byte == J2K_FF) && r_stuff;
    w_byte_valid  = 1'b0;
    w_byte        = r_byte;
    w_byte_last   = 1'b0;
    case (r_state)
      ST_ALIGN: w_byte_valid = 1'b1;
      ST_SHIFT: begin
        w_byte_valid = w_shift_close;
        w_byte       = w_shift_byte;
        w_byte_last  = r_last && (r_cnt == BIT_CNT_W'(1)) && !w_shift_ff;
      end
      ST_FLUSH: begin
        // A zero-padded byte can never be 0xFF, so it always ends the header.
        w_byte_valid = (r_bitpos != 3'd0);
        w_byte_last  = 1'b1;
      end
      ST_STUFF: begin
        w_byte_valid = 1'b1;
        w_byte       = J2K_STUFF_BYTE;
        w_byte_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b0;
      r_stuff  <= 1'b0;
      r_byte   <= '0;
      r_bitpos <= '0;
      r_ff     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (valid_i) begin
          r_data  <= hdr_data_i << (HDR_DATA_W - w_cnt_sat);
          r_cnt   <= w_cnt_sat;
          r_last  <= hdr_last_i;
          r_stuff <= insert_zero_i;
          if (!insert_zero_i && r_bitpos != 3'd0) r_state <= ST_ALIGN;
          else if (w_cnt_sat != '0)               r_state <= ST_SHIFT;
          else if (hdr_last_i)                    r_state <= ST_FLUSH;
        end
        ST_ALIGN: if (w_byte_ready) begin
          r_byte   <= '0;
          r_bitpos <= '0;
          r_ff     <= 1'b0;
          if (r_cnt != '0)  r_state <= ST_SHIFT;
          else if (r_last)  r_state <= ST_FLUSH;
          else              r_state <= ST_IDLE;
        end
        ST_SHIFT: if (!w_shift_close || w_byte_ready) begin
          r_data <= r_data << 1;
          r_cnt  <= r_cnt - 1'b1;
          if (w_shift_close) begin
            r_byte   <= '0;
            r_bitpos <= '0;
            r_ff     <= w_shift_ff;
          end else begin
            r_byte   <= w_shift_byte;
            r_bitpos <= w_pos + 3'd1;
          end
          if (r_cnt == BIT_CNT_W'(1)) r_state <= r_last ? ST_FLUSH : ST_IDLE;
        end
        ST_FLUSH: begin
          if (r_bitpos != 3'd0) begin
            if (w_byte_ready) begin
              r_byte   <= '0;
              r_bitpos <= '0;
              r_ff     <= 1'b0;
              r_state  <= ST_EMIT;
            end
          end else begin
            r_state <= r_ff ? ST_STUFF : ST_EMIT;
          end
        end
        ST_STUFF: if (w_byte_ready) begin
          r_ff    <= 1'b0;
          r_state <= ST_EMIT;
        end
        ST_EMIT: if (w_flush_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  hdr_byte_to_word #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_b2w (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (w_byte_valid),
    .byte_i       (w_byte),
    .byte_last_i  (w_byte_last),
    .byte_ready_o (w_byte_ready),
    .flush_i      (w_flush),
    .flush_done_o (w_flush_done),
    .m_valid_o    (m_axis_hdr_tx_valid_o),
    .m_data_o     (m_axis_hdr_tx_data_o),
    .m_keep_o     (m_axis_hdr_tx_keep_o),
    .m_last_o     (m_axis_hdr_tx_last_o),
    .m_ready_i    (m_axis_hdr_tx_ready_i)
  );

`ifdef HDR_PACK_STAT_EN
  logic [15:0] r_len_cnt;
  logic [15:0] r_len_hold;
  logic        w_acc;

  assign w_acc           = w_byte_valid && w_byte_ready;
  assign hdr_len_o       = r_len_hold;
  assign hdr_len_valid_o = m_axis_hdr_tx_valid_o && m_axis_hdr_tx_ready_i && m_axis_hdr_tx_last_o;

  // The total is latched when the final byte is taken, which always precedes
  // the transfer of the word carrying it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_cnt  <= '0;
      r_len_hold <= '0;
    end else if (w_acc && w_byte_last) begin
      r_len_hold <= r_len_cnt + 16'd1;
      r_len_cnt  <= '0;
    end else if (w_acc) begin
      r_len_cnt <= r_len_cnt + 16'd1;
    end else if (w_flush && w_flush_done && r_len_cnt != '0) begin
      r_len_hold <= r_len_cnt;
      r_len_cnt  <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_hdr_bit_pack.sv
// Directed bench for hdr_bit_pack (DATA_W = 32) with hand-computed output words.
module tb_hdr_bit_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        hdr_last_i;
  logic        insert_zero_i;
  logic [5:0]  bit_cnt_i;
  logic [31:0] hdr_data_i;
  logic        hdr_ready_o;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_ready;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hdr_bit_pack #(
    .DATA_W     (32),
    .KEEP_W     (4),
    .HDR_DATA_W (32),
    .BIT_CNT_W  (6)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .valid_i               (valid_i),
    .hdr_last_i            (hdr_last_i),
    .insert_zero_i         (insert_zero_i),
    .bit_cnt_i             (bit_cnt_i),
    .hdr_data_i            (hdr_data_i),
    .hdr_ready_o           (hdr_ready_o),
    .m_axis_hdr_tx_valid_o (m_valid),
    .m_axis_hdr_tx_data_o  (m_data),
    .m_axis_hdr_tx_keep_o  (m_keep),
    .m_axis_hdr_tx_last_o  (m_last),
    .m_axis_hdr_tx_ready_i (m_ready)
  );

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) q.push_back('{m_data, m_keep, m_last});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic stuff, input logic [5:0] cnt, input logic [31:0] data,
                      input logic last);
    int  waited = 0;
    logic ok = 1'b0;
    valid_i       = 1'b1;
    insert_zero_i = stuff;
    bit_cnt_i     = cnt;
    hdr_data_i    = data;
    hdr_last_i    = last;
    while (!ok && waited < 500) begin
      @(negedge clk);
      if (hdr_ready_o) ok = 1'b1;
      else waited++;
    end
    check_eq("send_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n);
    int w = 0;
    while (q.size() < n && w < 1000) begin
      @(posedge clk);
      w++;
    end
    tick(10);
    check_eq({tag, "_count"}, 64'(q.size()), 64'(n));
  endtask

  task automatic expect_word(input string tag, input int idx, input logic [31:0] d,
                             input logic [3:0] k, input logic l);
    word_t w;
    w = (idx < q.size()) ? q[idx] : '0;
    check_eq({tag, "_data"}, 64'(w.data), 64'(d));
    check_eq({tag, "_keep"}, 64'(w.keep), 64'(k));
    check_eq({tag, "_last"}, 64'(w.last), 64'(l));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_hdr_ready"}, 64'(hdr_ready_o), 64'd1);
    check_eq({tag, "_valid"},     64'(m_valid),     64'd0);
    check_eq({tag, "_data"},      64'(m_data),      64'd0);
    check_eq({tag, "_keep"},      64'(m_keep),      64'd0);
    check_eq({tag, "_last"},      64'(m_last),      64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n = 1'b0; valid_i = 1'b0; hdr_last_i = 1'b0; insert_zero_i = 1'b0;
    bit_cnt_i = '0; hdr_data_i = '0; m_ready = 1'b1;
    tick(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    send(1'b0, 6'd32, 32'hFF910004, 1'b0);
    send(1'b0, 6'd16, 32'h00000005, 1'b0);
    send(1'b1, 6'd1,  32'h00000001, 1'b1);
    wait_words("t1", 2);
    expect_word("t1w0", 0, 32'hFF910004, 4'b1111, 1'b0);
    expect_word("t1w1", 1, 32'h00058000, 4'b1110, 1'b1);
    q.delete();

    send(1'b1, 6'd8, 32'h000000FF, 1'b0);
    send(1'b1, 6'd4, 32'h0000000F, 1'b1);
    wait_words("t2", 1);
    expect_word("t2w0", 0, 32'hFF780000, 4'b1100, 1'b1);
    q.delete();

    send(1'b1, 6'd8, 32'h000000FF, 1'b1);
    wait_words("t3", 1);
    expect_word("t3w0", 0, 32'hFF000000, 4'b1100, 1'b1);
    q.delete();

    send(1'b1, 6'd3, 32'h00000005, 1'b0);
    send(1'b0, 6'd8, 32'h000000AB, 1'b1);
    wait_words("t4", 1);
    expect_word("t4w0", 0, 32'hA0AB0000, 4'b1100, 1'b1);
    q.delete();

    send(1'b1, 6'd40, 32'h12345678, 1'b1);
    wait_words("sat", 1);
    expect_word("satw0", 0, 32'h12345678, 4'b1111, 1'b1);
    q.delete();

    m_ready = 1'b0;
    send(1'b0, 6'd32, 32'hFF910004, 1'b0);
    send(1'b0, 6'd16, 32'h00000005, 1'b0);
    send(1'b1, 6'd1,  32'h00000001, 1'b1);
    tick(5);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!m_valid || m_data !== 32'hFF910004 || m_keep !== 4'b1111 || m_last !== 1'b0 ||
          hdr_ready_o !== 1'b0)
        bad++;
    end
    check_eq("stall_hold", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_words("t5", 2);
    expect_word("t5w0", 0, 32'hFF910004, 4'b1111, 1'b0);
    expect_word("t5w1", 1, 32'h00058000, 4'b1110, 1'b1);
    q.delete();

    send(1'b0, 6'd32, 32'hFF910004, 1'b0);
    tick(10);
    check_eq("midshift_busy", 64'(hdr_ready_o), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    q.delete();
    send(1'b0, 6'd32, 32'hFF910004, 1'b1);
    wait_words("t6", 1);
    expect_word("t6w0", 0, 32'hFF910004, 4'b1111, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hdr_bit_pack.md
Name: hdr_bit_pack

Overview:
- Sits directly downstream of the packet-header maker.
- Accepts variable-length header fields (hdr_data, bit_cnt) one per handshake and serializes them MSB-first into bytes.
- Applies JPEG2000 packet-header bit-stuffing: after an emitted 0xFF, the next byte carries only 7 bits, with MSB forced to 0.
- Packs the bytes big-endian into AXI-stream words, with keep and last, for the codestream writer.

Parameters:
- DATA_W, 32: output word width; multiple of 8.
- KEEP_W, DATA_W/8: keep width.
- HDR_DATA_W, 32: input field width.
- BIT_CNT_W, 6: bit count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- valid_i  in  1  field valid
- hdr_last_i  in  1  field is the last of the packet header
- insert_zero_i  in  1  1 = stuffed header field; 0 = raw byte-aligned field (markers, indices)
- bit_cnt_i  in  BIT_CNT_W  number of valid bits, taken from hdr_data_i[bit_cnt_i-1:0]
- hdr_data_i  in  HDR_DATA_W  field bits, right-aligned
- hdr_ready_o  out  1  field accepted when valid_i & hdr_ready_o
- m_axis_hdr_tx_valid_o  out  1  output valid
- m_axis_hdr_tx_data_o  out  DATA_W  first byte at [DATA_W-1:DATA_W-8]
- m_axis_hdr_tx_keep_o  out  KEEP_W  keep[KEEP_W-1-k] qualifies byte k
- m_axis_hdr_tx_last_o  out  1  word holds the final header byte
- m_axis_hdr_tx_ready_i  in  1  downstream ready

Behaviour:
- Reset: all outputs 0 except hdr_ready_o = 1; state IDLE; accumulator, bit position, ff_flag and word buffer cleared.
- Reset mid-operation discards the partial field, byte and word.
- Field capture:
  - hdr_ready_o = 1 only in IDLE.
  - On handshake, latch data, cnt, last and stuff flag.
  - bit_cnt_i > HDR_DATA_W saturates to HDR_DATA_W.
- States:
  - IDLE: on capture, go to ALIGN if raw and bit position ≠ 0; else SHIFT if cnt > 0; else FLUSH if last; else stay in IDLE.
  - ALIGN: pad the partial byte with 0s in one cycle, close it, then go to SHIFT.
  - SHIFT: one bit per cycle, MSB first.
    - Byte capacity is 7 when ff_flag is set and the field is stuffed (bit 7 written 0, filling starts at bit 6); else 8.
    - A byte closes when full. Closing sets ff_flag = (byte == 0xFF) & stuffed, otherwise clears it.
    - When cnt reaches 0: go to FLUSH if last, else IDLE.
  - FLUSH: if bit position ≠ 0, pad with 0s and close the byte. If ff_flag is still set after that, go to STUFF; else go to EMIT.
  - STUFF: append byte 0x00, clear ff_flag, go to EMIT.
  - EMIT: mark the current word last; send it even if partial; return to IDLE after the word transfers to the output register.
- Raw fields never set ff_flag.
- Byte-to-word path:
  - Closed bytes fill the word buffer at index k = 0..KEEP_W-1.
  - A full word, or a last word, moves to the output register when the register is empty or draining this cycle.
  - Otherwise the serializer stalls and holds its state; no byte is ever lost.
- Output register:
  - AXI rules: data, keep and last stay stable while valid & !ready.
  - Valid drops the cycle after a transfer unless refilled.
  - Keep is contiguous from the MSB byte.
- Latency: a field of n bits takes n cycles in SHIFT, plus 1 per ALIGN/FLUSH/STUFF. A completed word appears on the output the cycle after it closes.
- A header with no bits at all emits nothing; last is then lost. This is illegal upstream.

Optional Feature:
- HDR_PACK_STAT_EN adds two ports:
  - hdr_len_o, 16 bits: count of bytes emitted for the current header, including stuffed 0x00.
  - hdr_len_valid_o, 1 bit: pulses for one cycle when the last word transfers.
- The counter resets to 0 after the pulse and wraps at 16 bits.
- Without the macro, neither port nor the counter exists.

Decomposition:
- Package j2k_hdr_pkg holds:
  - the state encoding (IDLE, ALIGN, SHIFT, FLUSH, STUFF, EMIT);
  - J2K_FF = 8'hFF and the stuff byte 8'h00;
  - BIT_CNT_W and HDR_DATA_W defaults.
- Sub-module hdr_byte_to_word holds the byte-to-word buffer and the output register with the AXI handshake and stall signal.

Test Plan (DATA_W = 32):
- Raw 32'hFF910004/32, then raw 16'h0005/16, then stuffed 1'b1/1 with last -> words 0xFF910004 keep 1111, then 0x00058000 keep 1110 last.
- Stuffed 0xFF/8, then stuffed 0xF/4 with last -> 0xFF780000 keep 1100 last; the second byte is 0_1111_000.
- Stuffed 0xFF/8 with last -> 0xFF000000 keep 1100 last; checks the trailing stuff byte.
- Stuffed 3'b101/3, then raw 0xAB/8 with last -> 0xA0AB0000 keep 1100 last; checks ALIGN padding.
- Repeat the first scenario with m_axis_hdr_tx_ready_i low for 20 cycles mid-stream:
  - identical words result;
  - data is stable while stalled;
  - hdr_ready_o stays low during the stall.
- Drop rst_n mid-SHIFT of a 32-bit field -> all outputs 0 and hdr_ready_o = 1. A following 0xFF910004 raw field with last -> a single clean word 0xFF910004, keep 1111, last.
